// File: rtl/p_i_cache_plru_if.sv
// Fetch-side bus between the fetch stage (master) and the instruction cache (slave).
interface p_i_cache_plru_if;
  logic        mem_read;
  logic [31:0] mem_address;
  logic        if_id_reg_load;
  logic        flush;
  logic        mem_resp;
  logic [31:0] mem_rdata;

  modport master (
    output mem_read, mem_address, if_id_reg_load, flush,
    input  mem_resp, mem_rdata
  );

  modport slave (
    input  mem_read, mem_address, if_id_reg_load, flush,
    output mem_resp, mem_rdata
  );
endinterface

// File: rtl/p_i_cache_plru.sv
// Two-stage read-only instruction cache: flop arrays, combinational stage-1 lookup,
// registered stage-2 output, tree-PLRU replacement, single-cycle flush.
module p_i_cache_plru #(
  parameter int unsigned s_offset = 5,
  parameter int unsigned s_index  = 3,
  parameter int unsigned num_ways = 4,
  parameter int unsigned s_tag    = 32 - s_offset - s_index,
  parameter int unsigned s_line   = 8 * 2**s_offset
) (
  input  logic                 clk,
  input  logic                 rst,
  p_i_cache_plru_if.slave      fetch,
  output logic                 pmem_read,
  output logic [31:0]          pmem_address,
  input  logic [s_line-1:0]    pmem_rdata,
  input  logic                 pmem_resp
);

  localparam int unsigned num_sets = 2**s_index;
  localparam int unsigned idx_w    = (s_index > 0) ? s_index : 1;
  localparam int unsigned way_w    = (num_ways > 1) ? $clog2(num_ways) : 1;
  localparam int unsigned levels   = $clog2(num_ways);
  localparam int unsigned plru_w   = (num_ways > 1) ? num_ways - 1 : 1;
  localparam int unsigned word_w   = s_offset - 2;

  typedef enum logic {IDLE, FILL} state_t;

  state_t                            state_q;
  logic                              kill_q;
  logic [num_sets-1:0][num_ways-1:0] valid_q;
  logic [plru_w-1:0]                 plru_q [num_sets];
  logic [s_tag-1:0]                  tag_q  [num_sets][num_ways];
  logic [s_line-1:0]                 data_q [num_sets][num_ways];

  logic [idx_w-1:0]  req_idx, fill_idx;
  logic [s_tag-1:0]  req_tag, fill_tag;
  logic [word_w-1:0] req_word;
  logic              hit;
  logic [way_w-1:0]  hit_way, victim;
  logic [31:0]       hit_word;
  logic              deliver, start_fill, install;

  // Address decode for the request and for the registered fill address
  always_comb begin
    req_idx  = (s_index == 0) ? '0 : idx_w'(fetch.mem_address >> s_offset);
    fill_idx = (s_index == 0) ? '0 : idx_w'(pmem_address >> s_offset);
    req_tag  = s_tag'(fetch.mem_address >> (s_offset + s_index));
    fill_tag = s_tag'(pmem_address >> (s_offset + s_index));
    req_word = word_w'(fetch.mem_address >> 2);
  end

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < num_ways; w++) begin
      if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = way_w'(w);
      end
    end
    hit_word = data_q[req_idx][hit_way][32*int'(req_word) +: 32];
  end

  // Victim: lowest invalid way wins over the PLRU walk from the root
  always_comb begin
    int node;
    node = 0;
    for (int l = 0; l < levels; l++) begin
      node = 2*node + 1 + int'(plru_q[fill_idx][node]);
    end
    victim = way_w'(node - (int'(num_ways) - 1));
    for (int w = int'(num_ways) - 1; w >= 0; w--) begin
      if (!valid_q[fill_idx][w]) victim = way_w'(w);
    end
  end

  // Make every node on the path of way w point away from w
  function automatic logic [plru_w-1:0] plru_touch(input logic [plru_w-1:0] bits,
                                                   input logic [way_w-1:0]  w);
    logic [plru_w-1:0] res;
    int node;
    int parent;
    res  = bits;
    node = int'(w) + int'(num_ways) - 1;
    for (int l = 0; l < levels; l++) begin
      parent      = (node - 1) / 2;
      res[parent] = (node == 2*parent + 1);
      node        = parent;
    end
    return res;
  endfunction

  always_comb begin
    deliver    = (state_q == IDLE) && fetch.mem_read && hit && !fetch.flush && fetch.if_id_reg_load;
    start_fill = (state_q == IDLE) && fetch.mem_read && !hit && !fetch.flush;
    install    = (state_q == FILL) && pmem_resp && !kill_q && !fetch.flush;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      kill_q          <= 1'b0;
      pmem_read       <= 1'b0;
      pmem_address    <= '0;
      fetch.mem_resp  <= 1'b0;
      fetch.mem_rdata <= '0;
      valid_q         <= '0;
      for (int s = 0; s < num_sets; s++) plru_q[s] <= '0;
    end else begin
      if (fetch.if_id_reg_load) begin
        fetch.mem_resp <= deliver;
        if (deliver) fetch.mem_rdata <= hit_word;
      end
      if (deliver) plru_q[req_idx] <= plru_touch(plru_q[req_idx], hit_way);

      case (state_q)
        IDLE: begin
          if (start_fill) begin
            state_q      <= FILL;
            pmem_read    <= 1'b1;
            pmem_address <= {fetch.mem_address[31:s_offset], s_offset'(0)};
            kill_q       <= 1'b0;
          end
        end
        FILL: begin
          if (fetch.flush) kill_q <= 1'b1;
          if (pmem_resp) begin
            state_q   <= IDLE;
            pmem_read <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (install) begin
        valid_q[fill_idx][victim] <= 1'b1;
        plru_q[fill_idx]          <= plru_touch(plru_q[fill_idx], victim);
      end
      // Flush has the last word over any install or PLRU update this cycle
      if (fetch.flush) begin
        valid_q <= '0;
        for (int s = 0; s < num_sets; s++) plru_q[s] <= '0;
      end
    end
  end

  // Tag and data storage carry no reset; valid bits qualify them
  always_ff @(posedge clk) begin
    if (install) begin
      tag_q[fill_idx][victim]  <= fill_tag;
      data_q[fill_idx][victim] <= pmem_rdata;
    end
  end

endmodule

// File: doc/p_i_cache_plru.md
Name: p_i_cache_plru

Overview:
- Parametrised, two-stage pipelined, read-only instruction cache; the next generation of the fixed 4-way/8-set I-cache.
- Sits between the fetch stage and the instruction-side arbiter port.
- Generalises way count and set count, and replaces the fixed 3-bit LRU with tree-PLRU.
- Adds a single-cycle flush (fence.i support) and explicit stall hold tied to if_id_reg_load.

Parameters:
s_offset, 5, byte-offset bits; line = 2**s_offset bytes
s_index, 3, index bits; num_sets = 2**s_index
num_ways, 4, associativity; power of two, 1..8
s_tag, 32-s_offset-s_index, tag width (derived)
s_line, 8*2**s_offset, line width in bits (derived)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
mem_read  in  1  fetch request valid
mem_address  in  32  fetch byte address; bits [1:0] ignored
if_id_reg_load  in  1  downstream accepts; 0 = hold stage-2 output
flush  in  1  one-cycle pulse: invalidate entire cache
mem_resp  out  1  stage-2 data valid
mem_rdata  out  32  fetched instruction word
pmem_read  out  1  line fill request
pmem_address  out  32  line-aligned fill address
pmem_rdata  in  s_line  fill line data
pmem_resp  in  1  fill complete, pmem_rdata valid this cycle

Behaviour:
- Reset: mem_resp=0, mem_rdata=0, pmem_read=0, pmem_address=0, state=IDLE. All valid and PLRU bits cleared. Tag and data arrays are not reset.
- Arrays are flop-based; stage-1 lookup is combinational on mem_address.
- Index = mem_address[s_offset+s_index-1:s_offset].
- Word select = mem_address[s_offset-1:2].
- Stage 1 (IDLE): hit = any way with valid && tag match.
  - If mem_read && hit && !flush && if_id_reg_load: the stage-2 register captures the word and resp=1, and PLRU is updated for that set.
  - Hit latency: 1 cycle. Throughput: one hit per cycle.
- Stage-2 register:
  - Loads only when if_id_reg_load=1; when 0, mem_resp and mem_rdata hold unchanged and the stage-1 result is discarded (no PLRU update). The CPU holds mem_address.
  - If it loads while no hit is being delivered (mem_read=0, miss, flush, FILL), it loads resp=0.
- States: IDLE, FILL.
  - IDLE -> FILL on mem_read && !hit && !flush. The fill address is registered.
  - FILL: pmem_read=1 and pmem_address={tag,index,s_offset'b0} held stable until pmem_resp.
  - On the pmem_resp edge, the victim way receives data, tag, valid=1 and PLRU is updated; next state is IDLE.
  - The next cycle the replayed lookup hits, so miss latency = pmem latency + 2 cycles.
- Victim selection: lowest-index invalid way; otherwise the tree-PLRU victim.
  - Tree-PLRU uses num_ways-1 bits per set, heap-ordered with node 0 as root; bit=0 points left (lower ways).
  - On access to way w, every node on w's path is set to point away from w.
  - num_ways=1: no PLRU bits; victim is always way 0.
- Flush:
  - Any cycle: clears all valid and PLRU bits at the next edge; a same-cycle request gets no response and does not start a fill.
  - Flush during FILL: the transaction still runs to pmem_resp (no abandon), but the line is not installed (kill flag). Returns to IDLE and the replay misses again.
  - flush coincident with pmem_resp: flush wins; nothing is installed.
- pmem_resp outside FILL is ignored.
- Reset mid-fill: back to IDLE and pmem_read=0 next cycle. The memory side is reset by the same rst.

Test Plan:
- Cold miss, pmem latency 5: read 0x00000040 -> pmem_read with pmem_address 0x00000040; mem_resp 7 cycles after request with word 0 of the line; subsequent reads 0x44, 0x48 resp on consecutive cycles.
- Replacement, 4 ways, set 0: fill tags at 0x000, 0x100, 0x200, 0x300; re-hit 0x000, 0x200; miss 0x400 -> evicts way 1 (0x100); re-read 0x100 misses.
- Stall: hit on 0x40 then if_id_reg_load=0 for 3 cycles with address 0x44 -> mem_resp and mem_rdata hold 0x40's word; on release 0x44 resp next cycle.
- Flush: after filling 0x40, pulse flush; read 0x40 -> misses, refills.
- Flush in FILL: flush 2 cycles into a fill -> pmem_resp completes the fill, line not installed; replay misses and issues a second pmem_read.
- Parameter sweep: num_ways=1, 2, 8 and s_index=0, 4 -> same directed sequences pass; direct-mapped conflict 0x000/0x100 (s_index=3) alternates misses.
